// File: rtl/mem_ctrl_param.sv
// mem_ctrl_param: single-port RAM with 1-cycle registered reads, range check and a sequential clear engine.
// No backpressure: accesses are dropped while BUSY. `define MEM_TRISTATE_OUT_EN to float D_OUT whenever D_VALID=0.
module mem_ctrl_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] D_IN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              R_ENABLE,
  input  logic              W_ENABLE,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_VALID,
  output logic              ADDR_ERR,
  output logic              BUSY
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_busy;
  logic [DATA_W-1:0] r_dout;
  logic              r_dvld;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_range;
  logic              w_req;
  logic              w_ptr_last;
  logic [PTR_W-1:0]  w_idx;
  logic              w_we;
  logic [PTR_W-1:0]  w_widx;
  logic [DATA_W-1:0] w_wdat;

  // Full-width compare so out-of-range addresses never alias onto low words.
  assign w_in_range = (32'(ADDR) < 32'(DEPTH));
  assign w_req      = R_ENABLE | W_ENABLE;
  assign w_ptr_last = (r_ptr == PTR_W'(DEPTH - 1));
  assign w_idx      = ADDR[PTR_W-1:0];

  // A write only lands in RUN when no clear, no read and the address is valid.
  assign w_we   = (r_state == CLR) ||
                  ((r_state == RUN) && !CLEAR && W_ENABLE && !R_ENABLE && w_in_range);
  assign w_widx = (r_state == CLR) ? r_ptr : w_idx;
  assign w_wdat = (r_state == CLR) ? '0 : D_IN;

  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_widx] <= w_wdat;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= CLR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
      r_dout  <= '0;
      r_dvld  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_dvld <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        CLR: begin
          if (w_ptr_last) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + PTR_W'(1);
          end
        end
        RUN: begin
          if (CLEAR) begin
            r_state <= CLR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end else if (w_req && !w_in_range) begin
            r_err <= 1'b1;
          end else if (R_ENABLE) begin
            r_dout <= r_mem[w_idx];
            r_dvld <= 1'b1;
          end
        end
        default: r_state <= CLR;
      endcase
    end
  end

`ifdef MEM_TRISTATE_OUT_EN
  assign D_OUT = r_dvld ? r_dout : {DATA_W{1'bz}};
`else
  assign D_OUT = r_dout;
`endif
  assign D_VALID  = r_dvld;
  assign ADDR_ERR = r_err;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Bench for mem_ctrl_param: a 64-deep and a 48-deep instance share one stimulus stream,
// each tracked by a word-level model; directed steps add literal expectations.
module tb_mem_ctrl_param;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] D_IN;
  logic [7:0] ADDR;
  logic       R_ENABLE;
  logic       W_ENABLE;
  logic       CLEAR;

  wire  [7:0] d_out0, d_out1;
  logic       dvld0, dvld1, err0, err1, busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_ctrl_param #(.DATA_W(8), .DEPTH(64), .ADDR_W(8)) u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .D_IN(D_IN), .ADDR(ADDR),
    .R_ENABLE(R_ENABLE), .W_ENABLE(W_ENABLE), .CLEAR(CLEAR),
    .D_OUT(d_out0), .D_VALID(dvld0), .ADDR_ERR(err0), .BUSY(busy0)
  );

  mem_ctrl_param #(.DATA_W(8), .DEPTH(48), .ADDR_W(6)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .D_IN(D_IN), .ADDR(ADDR[5:0]),
    .R_ENABLE(R_ENABLE), .W_ENABLE(W_ENABLE), .CLEAR(CLEAR),
    .D_OUT(d_out1), .D_VALID(dvld1), .ADDR_ERR(err1), .BUSY(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_out(input logic [7:0] v, input logic vld);
`ifdef MEM_TRISTATE_OUT_EN
    return vld ? v : 8'hzz;
`else
    return v;
`endif
  endfunction

  // Model: a clear zeroes the whole array at once and then blocks access for DEPTH cycles.
  localparam int M_DEP [2] = '{64, 48};
  logic [7:0] m_mem  [2][64];
  int         m_busy [2];
  logic [7:0] m_dout [2];
  logic       m_dvld [2];
  logic       m_err  [2];

  always @(posedge CLK or negedge RESET_N) begin
    for (int k = 0; k < 2; k++) begin
      int a;
      a = (k == 0) ? int'(ADDR) : int'(ADDR[5:0]);
      if (!RESET_N) begin
        m_busy[k] = M_DEP[k];
        m_dout[k] = 8'h00;
        m_dvld[k] = 1'b0;
        m_err[k]  = 1'b0;
        for (int i = 0; i < 64; i++) m_mem[k][i] = 8'h00;
      end else begin
        m_dvld[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (m_busy[k] > 0) begin
          m_busy[k]--;
        end else if (CLEAR) begin
          m_busy[k] = M_DEP[k];
          for (int i = 0; i < 64; i++) m_mem[k][i] = 8'h00;
        end else if ((R_ENABLE || W_ENABLE) && a >= M_DEP[k]) begin
          m_err[k] = 1'b1;
        end else if (R_ENABLE) begin
          m_dout[k] = m_mem[k][a];
          m_dvld[k] = 1'b1;
        end else if (W_ENABLE) begin
          m_mem[k][a] = D_IN;
        end
      end
    end
  end

  always @(negedge CLK) begin
    check("cmp_busy0", busy0,  m_busy[0] > 0);
    check("cmp_dvld0", dvld0,  m_dvld[0]);
    check("cmp_err0",  err0,   m_err[0]);
    check("cmp_dout0", d_out0, exp_out(m_dout[0], m_dvld[0]));
    check("cmp_busy1", busy1,  m_busy[1] > 0);
    check("cmp_dvld1", dvld1,  m_dvld[1]);
    check("cmp_err1",  err1,   m_err[1]);
    check("cmp_dout1", d_out1, exp_out(m_dout[1], m_dvld[1]));
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_busy(input int start, output int n0, output int n1);
    n0 = start;
    n1 = 0;
    for (int i = 0; i < 200 && busy0; i++) begin
      cyc();
      n0++;
      if (!busy1 && n1 == 0) n1 = n0;
    end
    check("busy_timeout", busy0, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    ADDR = a; D_IN = d; W_ENABLE = 1'b1; R_ENABLE = 1'b0;
    cyc();
    W_ENABLE = 1'b0;
    check("wr_no_dvld", dvld0, 1'b0);
  endtask

  task automatic do_read(input string name, input logic [7:0] a, input logic [7:0] exp);
    ADDR = a; R_ENABLE = 1'b1; W_ENABLE = 1'b0;
    cyc();
    R_ENABLE = 1'b0;
    check({name, "_vld"}, dvld0, 1'b1);
    check(name, d_out0, exp);
  endtask

  initial begin
    int n0, n1;
    RESET_N = 1'b0; D_IN = 8'h00; ADDR = 8'h00;
    R_ENABLE = 1'b0; W_ENABLE = 1'b0; CLEAR = 1'b0;
    repeat (3) cyc();
    check("rst_busy", busy0, 1'b1);
    check("rst_dout", d_out0, exp_out(8'h00, 1'b0));
    RESET_N = 1'b1;

    // 1: power-up clear length, then cleared contents
    wait_busy(0, n0, n1);
    check("t1_busy_cycles0", n0, 64);
    check("t1_busy_cycles1", n1, 48);
    do_read("t1_rd5", 8'd5, 8'h00);

    // 2: read-after-write
    do_write(8'd0, 8'h01);
    do_read("t2_rd0", 8'd0, 8'h01);

    // 3: read wins over simultaneous write
    ADDR = 8'd0; D_IN = 8'hAA; R_ENABLE = 1'b1; W_ENABLE = 1'b1;
    cyc();
    R_ENABLE = 1'b0; W_ENABLE = 1'b0;
    check("t3_rw_vld", dvld0, 1'b1);
    check("t3_rw_dout", d_out0, 8'h01);
    do_read("t3_rd0_again", 8'd0, 8'h01);

    // 4: clear engine, write while busy is dropped
    do_write(8'd50, 8'h02);
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;
    check("t4_busy_set", busy0, 1'b1);
    ADDR = 8'd7; D_IN = 8'h33; W_ENABLE = 1'b1;
    cyc();
    W_ENABLE = 1'b0;
    wait_busy(1, n0, n1);
    check("t4_busy_cycles0", n0, 64);
    check("t4_busy_cycles1", n1, 48);
    do_read("t4_rd50", 8'd50, 8'h00);
    do_read("t4_rd7", 8'd7, 8'h00);

    // 5: out of range, no aliasing onto word 6
    do_write(8'd6, 8'h66);
    do_read("t5_pre_rd6", 8'd6, 8'h66);
    ADDR = 8'd70; D_IN = 8'h02; R_ENABLE = 1'b1; W_ENABLE = 1'b1;
    cyc();
    R_ENABLE = 1'b0; W_ENABLE = 1'b0;
    check("t5_err", err0, 1'b1);
    check("t5_no_vld", dvld0, 1'b0);
    check("t5_dout_hold", d_out0, exp_out(8'h66, 1'b0));
    cyc();
    check("t5_err_pulse", err0, 1'b0);
    do_read("t5_rd6", 8'd6, 8'h66);

    // 6: reset mid-clear, then the 48-deep range check
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;
    repeat (20) cyc();
    check("t6_pre_dout", d_out0, exp_out(8'h66, 1'b0));
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_rst_busy", busy0, 1'b1);
    check("t6_rst_dvld", dvld0, 1'b0);
    check("t6_rst_err", err0, 1'b0);
    check("t6_rst_dout", d_out0, exp_out(8'h00, 1'b0));
    repeat (3) cyc();
    RESET_N = 1'b1;
    wait_busy(0, n0, n1);
    check("t6_busy_cycles0", n0, 64);
    check("t6_busy_cycles1", n1, 48);
    ADDR = 8'd50; R_ENABLE = 1'b1;
    cyc();
    R_ENABLE = 1'b0;
    check("t6_err48", err1, 1'b1);
    check("t6_no_vld48", dvld1, 1'b0);
    check("t6_vld64", dvld0, 1'b1);
    check("t6_dout64", d_out0, 8'h00);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_ctrl_param.md
Name: mem_ctrl_param

Overview:
- Parametrised single-port synchronous memory. It is the generalised successor of the team's fixed 64 x 8 byte memory.
- Adds configurable width and depth, registered reads with a valid strobe, and an out-of-range error flag.
- Adds a sequential hardware clear engine, which replaces the instant array reset.
- Sits between a lab datapath/controller and local storage. Used as scratch RAM and register file backing.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 64, number of words; need not be a power of two
ADDR_W, 8, width of ADDR port; must satisfy 2^ADDR_W >= DEPTH

Ports:
CLK  input  1  system clock, all state on rising edge
RESET_N  input  1  asynchronous, active-low reset
D_IN  input  DATA_W  write data
ADDR  input  ADDR_W  word address
R_ENABLE  input  1  read request
W_ENABLE  input  1  write request
CLEAR  input  1  start sequential clear of the whole array
D_OUT  output  DATA_W  registered read data
D_VALID  output  1  D_OUT holds data from a successful read issued the previous cycle
ADDR_ERR  output  1  previous-cycle access had ADDR >= DEPTH
BUSY  output  1  clear engine active; accesses ignored

Behaviour:
- Reset: RESET_N low forces D_OUT=0, D_VALID=0, ADDR_ERR=0, BUSY=1, state=CLR, clear pointer=0 immediately, with no wait for a clock edge.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM has two states, CLR and RUN.
- CLR state:
  - Writes 0 to mem[ptr] each cycle and increments ptr.
  - When ptr==DEPTH-1 is written, the next state is RUN and BUSY drops on that same edge. BUSY is therefore high for exactly DEPTH cycles after reset release or after CLEAR is sampled.
  - R_ENABLE, W_ENABLE and CLEAR are ignored. D_VALID=0 and ADDR_ERR=0 throughout.
- RUN state, evaluated per rising edge with priority CLEAR > range check > read > write:
  - CLEAR=1: next state CLR, ptr=0, BUSY=1 next cycle. Any same-cycle R/W is discarded.
  - (R_ENABLE or W_ENABLE) with ADDR >= DEPTH: no array change; ADDR_ERR=1 next cycle; D_VALID=0; D_OUT holds. The comparison uses full ADDR_W bits with no aliasing or truncation.
  - R_ENABLE=1 with ADDR in range: D_OUT <= mem[ADDR] and D_VALID=1 next cycle (1-cycle latency).
    - If W_ENABLE is also 1, the write is suppressed, because read has priority.
  - W_ENABLE=1, R_ENABLE=0, ADDR in range: mem[ADDR] <= D_IN. D_VALID=0 next cycle.
  - No request: D_VALID=0 and ADDR_ERR=0 next cycle; D_OUT holds.
- D_VALID and ADDR_ERR are single-cycle, per-access strobes. Back-to-back reads give D_VALID high continuously.
- Read-after-write: a write in cycle N followed by a read of the same address in cycle N+1 returns the new data in cycle N+2.
- Reset asserted mid-clear: everything returns to reset values and the clear restarts from ptr=0 after release.
- Clear pointer width is clog2(DEPTH). The pointer never exceeds DEPTH-1.

Optional Feature:
- Macro: MEM_TRISTATE_OUT_EN.
- Defined: D_OUT is driven to all-Z whenever D_VALID=0, including during reset, BUSY and error cycles. This gives legacy shared-bus compatibility.
- Undefined: D_OUT is never Z. It holds its last read value (0 after reset), and consumers qualify it with D_VALID.

Test Plan:
1. Release RESET_N -> BUSY=1 for exactly 64 CLK cycles, then 0. Read ADDR=5 -> D_OUT=0x00 and D_VALID=1 one cycle later.
2. Write D_IN=0x01 to ADDR=0, then read ADDR=0 the next cycle -> D_OUT=0x01 and D_VALID=1 one cycle after the read. D_VALID=0 in the cycle following the write.
3. R_ENABLE=W_ENABLE=1, ADDR=0, D_IN=0xAA -> D_OUT=0x01. A subsequent read of ADDR=0 still returns 0x01.
4. Write 0x02 to ADDR=50, then pulse CLEAR -> BUSY for 64 cycles.
   - A write of 0x33 to ADDR=7 issued while BUSY is ignored.
   - Afterwards, reads of ADDR=50 and ADDR=7 both return 0x00.
5. R_ENABLE=W_ENABLE=1, ADDR=70, D_IN=0x02 -> ADDR_ERR=1 for one cycle, D_VALID=0, D_OUT unchanged (Z with MEM_TRISTATE_OUT_EN). A read of ADDR=6 returns its prior value, proving no aliasing.
6. Assert RESET_N low while the clear pointer is at 20 -> outputs are at reset values immediately. After release, BUSY stays high for a full 64 cycles. Repeat with DEPTH=48, ADDR_W=6: ADDR=50 raises ADDR_ERR.
